btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences updates into the single-ported branch target buffer (BTB) write port.
- Filters resolved branches from EX so only BTB misses and wrong targets cause a write.
- Buffers pending writes in a small FIFO and drains it one entry per non-stalled cycle.
- Runs a clear sweep over all BTB sets on request; sits between EX branch resolution and the BTB.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, >=2)
- S_OFFSET, 2, BTB offset bits; must match the BTB instance
- S_INDEX, 2, BTB index bits; NUM_SETS = 2**S_INDEX

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- resolve_valid  in  1  EX has a resolved control-flow instruction this cycle
- resolve_pc  in  32  PC of the resolved instruction
- resolve_target  in  32  actual target
- resolve_taken  in  1  branch/jump taken
- resolve_btb_hit  in  1  the BTB hit when this instruction was fetched
- resolve_pred_target  in  32  BTB target supplied at fetch
- pc_stall  in  1  BTB ignores writes while high
- flush_req  in  1  single-cycle pulse: clear every BTB set
- btb_write  out  1  BTB write enable
- btb_wpc  out  32  write PC (drives BTB ex_pc)
- btb_wdata  out  32  write target
- flush_busy  out  1  clear sweep in progress
- q_count  out  $clog2(DEPTH+1)  FIFO occupancy
- drop_count  out  16  updates dropped because the FIFO was full; saturates at 16'hFFFF

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, state IDLE, sweep index 0, and all outputs 0 (btb_write, btb_wpc, btb_wdata, flush_busy, q_count, drop_count).
- Update filter: an update is wanted when resolve_valid && resolve_taken && (!resolve_btb_hit || resolve_pred_target != resolve_target). Not-taken resolutions never generate a write.
- FIFO entry: {pc, target}. FIFO pointers wrap modulo DEPTH.
- Write handshake:
  - btb_write, btb_wpc and btb_wdata are combinational from the FIFO head or the sweep index.
  - A write is consumed at a rising edge where btb_write && !pc_stall.
  - While pc_stall is high, the outputs are held unchanged and the entry is retained.
- Write latency: an update into an empty FIFO (IDLE) appears on btb_write the next cycle.
- FSM:
  - IDLE: FIFO empty, btb_write=0. A wanted update goes to DRAIN. flush_req goes to SWEEP.
  - DRAIN: btb_write=1 with the head entry. Pop on consume. Go to IDLE when the last entry pops and no push occurs that cycle. flush_req goes to SWEEP.
  - SWEEP: flush_busy=1, btb_write=1, btb_wpc = idx << S_OFFSET (all other bits 0), btb_wdata=0.
    - idx increments on each consume.
    - After consuming idx = NUM_SETS-1, clear idx and go to IDLE.
- flush_req in any state: the FIFO is emptied in the same edge and SWEEP starts next cycle with idx=0. A flush_req during SWEEP restarts at idx=0.
- During SWEEP, and in the flush_req cycle itself, wanted updates are discarded and not counted in drop_count.
- Coalescing: if a wanted update's pc equals the tail entry's pc, the tail target is overwritten and no push occurs. Exception: when tail==head and the head is consumed that same edge, the update is pushed normally.
- Full FIFO:
  - If a pop occurs the same edge, the push succeeds (occupancy stays DEPTH).
  - Otherwise the update is dropped and drop_count increments, saturating.
  - A coalesce into a full FIFO is not a drop.
- Empty FIFO with a simultaneous push: no bypass; the entry appears the next cycle.
- q_count is always the registered occupancy and never exceeds DEPTH.

Test Plan:
- Reset mid-DRAIN with 3 queued entries, then rst low -> immediately btb_write=0, q_count=0, drop_count=0; after release the BTB receives no further writes.
- Miss update pc=0x100, target=0x240, hit=0 -> next cycle btb_write=1, btb_wpc=0x100, btb_wdata=0x240. Hit with pred_target==target -> no write. Not-taken -> no write.
- pc_stall held high 5 cycles with 2 queued entries -> outputs stable for 5 cycles. Then stall low -> entries written on consecutive edges in order, then IDLE.
- Stall high, push 4 distinct updates plus a 5th -> q_count=4, drop_count=1. Then push pc equal to the tail with a new target -> no drop, and the tail drains with the new target.
- flush_req with 2 queued entries -> FIFO cleared; flush_busy=1 for 4 non-stalled cycles; writes btb_wpc=0x0,0x4,0x8,0xC with wdata=0. A resolve during the sweep is ignored.
- Full FIFO with a consume and a distinct push on the same edge -> q_count stays 4, drop_count unchanged, new entry written last.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: filters EX resolutions, queues BTB writes,
// and runs a clear sweep over every BTB set on request.
module btb_update_ctrl #(
    parameter int DEPTH    = 4,
    parameter int S_OFFSET = 2,
    parameter int S_INDEX  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       resolve_valid,
    input  logic [31:0]                resolve_pc,
    input  logic [31:0]                resolve_target,
    input  logic                       resolve_taken,
    input  logic                       resolve_btb_hit,
    input  logic [31:0]                resolve_pred_target,
    input  logic                       pc_stall,
    input  logic                       flush_req,
    output logic                       btb_write,
    output logic [31:0]                btb_wpc,
    output logic [31:0]                btb_wdata,
    output logic                       flush_busy,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic [15:0]                drop_count
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]        pc_q  [DEPTH];
    logic [31:0]        tgt_q [DEPTH];
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [PW-1:0]      last_ptr;
    logic [CW-1:0]      count_q;
    logic [S_INDEX-1:0] idx_q;
    logic [15:0]        drop_q;

    logic consume;
    logic pop;
    logic want;
    logic accept;
    logic coal;
    logic push;
    logic drop;
    logic full;
    logic last_idx;

    assign last_ptr = tail_q - PW'(1);
    assign full     = (count_q == CW'(DEPTH));
    assign last_idx = (idx_q == S_INDEX'(NUM_SETS - 1));

    assign want = resolve_valid && resolve_taken &&
                  (!resolve_btb_hit ||
                   (resolve_pred_target != resolve_target));

    assign consume = btb_write && !pc_stall;
    assign pop     = (state_q == DRAIN) && consume && !flush_req;
    assign accept  = want && (state_q != SWEEP) && !flush_req;

    // A lone entry leaving this edge cannot absorb a coalesce.
    assign coal = accept && (count_q != '0) &&
                  (pc_q[last_ptr] == resolve_pc) &&
                  !((count_q == CW'(1)) && pop);

    assign push = accept && !coal && (!full || pop);
    assign drop = accept && !coal && full && !pop;

    always_comb begin
        btb_write  = 1'b0;
        btb_wpc    = '0;
        btb_wdata  = '0;
        flush_busy = 1'b0;
        unique case (state_q)
            DRAIN: begin
                btb_write = 1'b1;
                btb_wpc   = pc_q[head_q];
                btb_wdata = tgt_q[head_q];
            end
            SWEEP: begin
                btb_write  = 1'b1;
                flush_busy = 1'b1;
                btb_wpc    = 32'(idx_q) << S_OFFSET;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = SWEEP;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (push) state_d = DRAIN;
                end
                DRAIN: begin
                    if (pop && (count_q == CW'(1)) && !push)
                        state_d = IDLE;
                end
                SWEEP: begin
                    if (consume && last_idx) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_req) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop)  head_q <= head_q + PW'(1);
            if (push) tail_q <= tail_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]  <= resolve_pc;
            tgt_q[tail_q] <= resolve_target;
        end else if (coal) begin
            tgt_q[last_ptr] <= resolve_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (flush_req) begin
            idx_q <= '0;
        end else if ((state_q == SWEEP) && consume) begin
            idx_q <= last_idx ? '0 : idx_q + S_INDEX'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign q_count    = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: expected BTB writes queue up as
// stimulus is driven and are matched as the DUT consumes them.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [31:0] resolve_target;
    logic        resolve_taken;
    logic        resolve_btb_hit;
    logic [31:0] resolve_pred_target;
    logic        pc_stall;
    logic        flush_req;
    logic        btb_write;
    logic [31:0] btb_wpc;
    logic [31:0] btb_wdata;
    logic        flush_busy;
    logic [2:0]  q_count;
    logic [15:0] drop_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] sb[$];

    btb_update_ctrl #(
        .DEPTH(4),
        .S_OFFSET(2),
        .S_INDEX(2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .resolve_valid      (resolve_valid),
        .resolve_pc         (resolve_pc),
        .resolve_target     (resolve_target),
        .resolve_taken      (resolve_taken),
        .resolve_btb_hit    (resolve_btb_hit),
        .resolve_pred_target(resolve_pred_target),
        .pc_stall           (pc_stall),
        .flush_req          (flush_req),
        .btb_write          (btb_write),
        .btb_wpc            (btb_wpc),
        .btb_wdata          (btb_wdata),
        .flush_busy         (flush_busy),
        .q_count            (q_count),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; any write the BTB takes is matched against the scoreboard.
    task automatic step();
        logic [63:0] exp;
        @(negedge clk);
        if (rst && btb_write && !pc_stall) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_write: got pc=%h data=%h want none",
                         btb_wpc, btb_wdata);
            end else begin
                exp = sb.pop_front();
                if ({btb_wpc, btb_wdata} !== exp)
                    $display("FAIL sb_write: got pc=%h data=%h want pc=%h data=%h",
                             btb_wpc, btb_wdata, exp[63:32], exp[31:0]);
                else
                    pass_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic taken, input logic hit,
                               input logic [31:0] pred);
        resolve_valid       = 1'b1;
        resolve_pc          = pc;
        resolve_target      = tgt;
        resolve_taken       = taken;
        resolve_btb_hit     = hit;
        resolve_pred_target = pred;
    endtask

    task automatic clear_resolve();
        resolve_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        resolve_valid = 1'b0;
        resolve_pc = '0;
        resolve_target = '0;
        resolve_taken = 1'b0;
        resolve_btb_hit = 1'b0;
        resolve_pred_target = '0;
        pc_stall = 1'b0;
        flush_req = 1'b0;
        #2;
        total_cnt++;
        if ({btb_write, flush_busy, btb_wpc, btb_wdata} !== 66'd0)
            $display("FAIL reset_write: got w=%b b=%b pc=%h d=%h want zeros",
                     btb_write, flush_busy, btb_wpc, btb_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({q_count, drop_count} !== 19'd0)
            $display("FAIL reset_counts: got q=%0d drop=%0d want 0 0",
                     q_count, drop_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_resolve(32'h100, 32'h240, 1'b1, 1'b0, 32'h0);
        sb.push_back({32'h100, 32'h240});
        step();
        clear_resolve();
        total_cnt++;
        if ({btb_write, btb_wpc, btb_wdata} !== {1'b1, 32'h100, 32'h240})
            $display("FAIL basic_latency: got w=%b pc=%h d=%h want 1 100 240",
                     btb_write, btb_wpc, btb_wdata);
        else pass_cnt++;
        step();
        set_resolve(32'h104, 32'h300, 1'b1, 1'b1, 32'h300);
        step();
        clear_resolve();
        total_cnt++;
        if (btb_write !== 1'b0)
            $display("FAIL basic_hit_ok: got w=%b want 0", btb_write);
        else pass_cnt++;
        set_resolve(32'h108, 32'h500, 1'b0, 1'b0, 32'h0);
        step();
        clear_resolve();
        total_cnt++;
        if ({btb_write, q_count} !== 4'b0000)
            $display("FAIL basic_not_taken: got w=%b q=%0d want 0 0",
                     btb_write, q_count);
        else pass_cnt++;
        set_resolve(32'h10C, 32'h600, 1'b1, 1'b1, 32'h700);
        sb.push_back({32'h10C, 32'h600});
        step();
        clear_resolve();
        total_cnt++;
        if ({btb_write, btb_wpc} !== {1'b1, 32'h10C})
            $display("FAIL basic_wrong_tgt: got w=%b pc=%h want 1 10c",
                     btb_write, btb_wpc);
        else pass_cnt++;
        step();
    endtask

    task automatic test_stall();
        pc_stall = 1'b1;
        set_resolve(32'h200, 32'h2A0, 1'b1, 1'b0, 32'h0);
        sb.push_back({32'h200, 32'h2A0});
        step();
        set_resolve(32'h300, 32'h3B0, 1'b1, 1'b0, 32'h0);
        sb.push_back({32'h300, 32'h3B0});
        step();
        clear_resolve();
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({btb_write, btb_wpc, btb_wdata, q_count} !==
                {1'b1, 32'h200, 32'h2A0, 3'd2})
                $display("FAIL stall_hold_%0d: got w=%b pc=%h d=%h q=%0d want 1 200 2a0 2",
                         i, btb_write, btb_wpc, btb_wdata, q_count);
            else pass_cnt++;
            step();
        end
        pc_stall = 1'b0;
        step();
        total_cnt++;
        if ({btb_write, btb_wpc, btb_wdata} !== {1'b1, 32'h300, 32'h3B0})
            $display("FAIL stall_second: got w=%b pc=%h d=%h want 1 300 3b0",
                     btb_write, btb_wpc, btb_wdata);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({btb_write, q_count} !== 4'b0000)
            $display("FAIL stall_idle: got w=%b q=%0d want 0 0", btb_write, q_count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        pc_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_resolve(32'h400 + 32'(i * 4), 32'h800 + 32'(i * 4), 1'b1, 1'b0, 32'h0);
            if (i < 4) sb.push_back({32'h400 + 32'(i * 4), 32'h800 + 32'(i * 4)});
            step();
        end
        clear_resolve();
        total_cnt++;
        if ({q_count, drop_count} !== {3'd4, 16'd1})
            $display("FAIL full_drop: got q=%0d drop=%0d want 4 1", q_count, drop_count);
        else pass_cnt++;
        set_resolve(32'h40C, 32'h999, 1'b1, 1'b0, 32'h0);
        sb[sb.size() - 1] = {32'h40C, 32'h999};
        step();
        clear_resolve();
        total_cnt++;
        if ({q_count, drop_count} !== {3'd4, 16'd1})
            $display("FAIL full_coalesce: got q=%0d drop=%0d want 4 1",
                     q_count, drop_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        pc_stall = 1'b0;
        set_resolve(32'h500, 32'h550, 1'b1, 1'b0, 32'h0);
        sb.push_back({32'h500, 32'h550});
        step();
        clear_resolve();
        total_cnt++;
        if ({q_count, drop_count} !== {3'd4, 16'd1})
            $display("FAIL b2b_push_pop: got q=%0d drop=%0d want 4 1",
                     q_count, drop_count);
        else pass_cnt++;
        n = 0;
        while (btb_write && n < 20) begin
            step();
            n++;
        end
        total_cnt++;
        if (n != 4 || sb.size() != 0 || q_count !== 3'd0)
            $display("FAIL b2b_drain: got cycles=%0d left=%0d q=%0d want 4 0 0",
                     n, sb.size(), q_count);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int n;
        pc_stall = 1'b1;
        set_resolve(32'h600, 32'h660, 1'b1, 1'b0, 32'h0);
        step();
        set_resolve(32'h604, 32'h664, 1'b1, 1'b0, 32'h0);
        step();
        clear_resolve();
        total_cnt++;
        if (q_count !== 3'd2)
            $display("FAIL flush_pre: got q=%0d want 2", q_count);
        else pass_cnt++;
        flush_req = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back({32'(i * 4), 32'h0});
        step();
        flush_req = 1'b0;
        total_cnt++;
        if ({q_count, flush_busy, btb_write, btb_wpc, btb_wdata} !==
            {3'd0, 1'b1, 1'b1, 32'h0, 32'h0})
            $display("FAIL flush_start: got q=%0d b=%b w=%b pc=%h d=%h want 0 1 1 0 0",
                     q_count, flush_busy, btb_write, btb_wpc, btb_wdata);
        else pass_cnt++;
        pc_stall = 1'b0;
        set_resolve(32'h700, 32'h777, 1'b1, 1'b0, 32'h0);
        n = 0;
        while (flush_busy && n < 20) begin
            step();
            clear_resolve();
            n++;
        end
        total_cnt++;
        if (n != 4)
            $display("FAIL flush_len: got %0d cycles want 4", n);
        else pass_cnt++;
        total_cnt++;
        if ({btb_write, q_count, drop_count} !== {1'b0, 3'd0, 16'd1} || sb.size() != 0)
            $display("FAIL flush_end: got w=%b q=%0d drop=%0d left=%0d want 0 0 1 0",
                     btb_write, q_count, drop_count, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        pc_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_resolve(32'h900 + 32'(i * 4), 32'hA00 + 32'(i * 4), 1'b1, 1'b0, 32'h0);
            step();
        end
        clear_resolve();
        total_cnt++;
        if ({btb_write, q_count} !== {1'b1, 3'd3})
            $display("FAIL rst_pre: got w=%b q=%0d want 1 3", btb_write, q_count);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({btb_write, q_count, drop_count} !== 20'd0)
            $display("FAIL rst_async: got w=%b q=%0d drop=%0d want 0 0 0",
                     btb_write, q_count, drop_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pc_stall = 1'b0;
        repeat (10) step();
        total_cnt++;
        if ({btb_write, q_count} !== 4'b0000)
            $display("FAIL rst_after: got w=%b q=%0d want 0 0", btb_write, q_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
